// File: rtl/shared_timer_arb.sv
// Round-robin arbiter that lends one WIDTH-bit up-counter to two requesters.
// A granted requester's len is latched as the terminal count; done pulses one cycle after the count reaches it.
module shared_timer_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] cnt_out
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic             last;
    logic             win;
    logic             win_active;

    // Both requesting: serve the one that did not finish last. last=1 after reset so req0 wins first.
    function automatic logic pick_winner(input logic [1:0] r, input logic l);
        return (r == 2'b11) ? ~l : r[1];
    endfunction

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        win        = pick_winner(req, last);
        win_active = |(req & gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            cnt_out <= '0;
            target  <= '0;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state   <= COUNT;
                        gnt     <= onehot(win);
                        busy    <= 1'b1;
                        cnt_out <= '0;
                        target  <= win ? len1 : len0;
                    end
                end
                COUNT: begin
                    // Winner dropped its request: abort without done; round-robin history untouched.
                    if (!win_active) begin
                        state   <= IDLE;
                        gnt     <= 2'b00;
                        busy    <= 1'b0;
                        cnt_out <= '0;
                    end else if (cnt_out == target) begin
                        state <= DONE;
                        done  <= gnt;
                    end else begin
                        cnt_out <= cnt_out + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    gnt     <= 2'b00;
                    done    <= 2'b00;
                    busy    <= 1'b0;
                    cnt_out <= '0;
                    last    <= gnt[1];
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= 2'b00;
                    done    <= 2'b00;
                    busy    <= 1'b0;
                    cnt_out <= '0;
                end
            endcase
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_done_in_gnt: assert property (@(posedge clk) disable iff (rst) (done & ~gnt) == 2'b00);
    a_busy_state:  assert property (@(posedge clk) disable iff (rst) busy == (state != IDLE));

endmodule
